// File: rtl/dmem_responder.sv
// dmem_responder
//   Data-memory target for the RV32I load/store port. Performs byte, half and
//   word accesses on an internal word-wide RAM. Loads are returned already
//   sign- or zero-extended. An access that crosses a word boundary takes two
//   RAM cycles.
//
// Ports
//   clk, reset        clock; synchronous active-high reset
//   mem_address_i     byte address
//   wr_width_i        funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   mem_read_ctrl_i   load request, held until mem_ready_o
//   mem_write_ctrl_i  store request, held until mem_ready_o
//   mem_write_data_i  store data; B/H use the low bytes
//   mem_read_data_o   extended load data, nonzero only in the ready cycle
//   mem_ready_o       one-cycle completion pulse
//   mem_err_o         request rejected; qualified by mem_ready_o
//
// state  | meaning
// IDLE   | waiting; request inputs are sampled only here
// FIRST  | access word widx
// SECOND | access word widx+1 (split accesses only)
// DONE   | ready pulse, result and error presented
module dmem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0002_0000,
  parameter int          DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mem_address_i,
  input  logic [2:0]  wr_width_i,
  input  logic        mem_read_ctrl_i,
  input  logic        mem_write_ctrl_i,
  input  logic [31:0] mem_write_data_i,
  output logic [31:0] mem_read_data_o,
  output logic        mem_ready_o,
  output logic        mem_err_o
);

  localparam int          AW    = $clog2(DEPTH_WORDS);
  localparam logic [32:0] LIMIT = 33'(4 * DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, FIRST, SECOND, DONE} state_t;

  state_t state, state_nxt;

  logic [31:0] ram [DEPTH_WORDS];

  // request decode, only meaningful in IDLE
  logic        req_c;
  logic [31:0] off_c;
  logic [32:0] end_c;
  logic [2:0]  size_c;
  logic [3:0]  mask_c;
  logic        width_bad_c;
  logic        err_c;
  logic [7:0]  be_c;
  logic [63:0] wdata_c;

  // latched request
  logic [AW-1:0] widx_q;
  logic [AW-1:0] widx_nx;
  logic [1:0]    boff_q;
  logic [2:0]    width_q;
  logic          wr_q;
  logic          err_q;
  logic [7:0]    be_q;
  logic [63:0]   wdata_q;
  logic [63:0]   asm_q;
  logic          split;
  logic [31:0]   raw;

  assign req_c = mem_read_ctrl_i | mem_write_ctrl_i;
  assign off_c = mem_address_i - BASE_ADDR;

  always_comb begin
    size_c      = 3'd1;
    mask_c      = 4'b0001;
    width_bad_c = 1'b0;
    case (wr_width_i)
      3'b000, 3'b100: begin size_c = 3'd1; mask_c = 4'b0001; end
      3'b001, 3'b101: begin size_c = 3'd2; mask_c = 4'b0011; end
      3'b010:         begin size_c = 3'd4; mask_c = 4'b1111; end
      default:        width_bad_c = 1'b1;
    endcase
  end

  // 33-bit end offset so an address near the top of the space cannot wrap
  assign end_c = {1'b0, off_c} + {30'b0, size_c} - 33'd1;
  assign err_c = (mem_read_ctrl_i & mem_write_ctrl_i) | width_bad_c |
                 (mem_address_i < BASE_ADDR) | (end_c >= LIMIT);

  // Lanes/bytes for both words at once: [3:0]/[31:0] is word widx,
  // [7:4]/[63:32] is word widx+1.
  assign be_c    = {4'b0, mask_c} << off_c[1:0];
  assign wdata_c = {32'b0, mem_write_data_i} << {off_c[1:0], 3'b000};

  assign split   = |be_q[7:4];
  assign widx_nx = widx_q + AW'(1);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_c) state_nxt = err_c ? DONE : FIRST;
      FIRST:   state_nxt = split ? SECOND : DONE;
      SECOND:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      widx_q  <= '0;
      boff_q  <= 2'd0;
      width_q <= 3'd0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      be_q    <= 8'd0;
      wdata_q <= 64'd0;
      asm_q   <= 64'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_c) begin
            widx_q  <= off_c[AW+1:2];
            boff_q  <= off_c[1:0];
            width_q <= wr_width_i;
            wr_q    <= mem_write_ctrl_i;
            err_q   <= err_c;
            be_q    <= be_c;
            wdata_q <= wdata_c;
            asm_q   <= 64'd0;
          end
        end
        FIRST:   if (!wr_q) asm_q[31:0]  <= ram[widx_q];
        SECOND:  if (!wr_q) asm_q[63:32] <= ram[widx_nx];
        default: ;
      endcase
    end
  end

  // RAM has no reset; the reset gate keeps an in-flight store from landing.
  always_ff @(posedge clk) begin
    if (!reset && wr_q) begin
      for (int i = 0; i < 4; i++) begin
        if (state == FIRST && be_q[i])
          ram[widx_q][8*i +: 8] <= wdata_q[8*i +: 8];
        if (state == SECOND && be_q[4+i])
          ram[widx_nx][8*i +: 8] <= wdata_q[32+8*i +: 8];
      end
    end
  end

  // little-endian reassembly: the requested bytes start at lane boff
  assign raw = asm_q[{boff_q, 3'b000} +: 32];

  always_comb begin
    mem_ready_o     = (state == DONE);
    mem_err_o       = (state == DONE) && err_q;
    mem_read_data_o = 32'd0;
    if (state == DONE && !err_q && !wr_q) begin
      case (width_q)
        3'b000:  mem_read_data_o = {{24{raw[7]}}, raw[7:0]};
        3'b001:  mem_read_data_o = {{16{raw[15]}}, raw[15:0]};
        3'b100:  mem_read_data_o = {24'd0, raw[7:0]};
        3'b101:  mem_read_data_o = {16'd0, raw[15:0]};
        default: mem_read_data_o = raw;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam logic [31:0] B     = 32'h0002_0000;
  localparam int          DEPTH = 1024;

  localparam logic [2:0] W_B  = 3'b000;
  localparam logic [2:0] W_H  = 3'b001;
  localparam logic [2:0] W_W  = 3'b010;
  localparam logic [2:0] W_BU = 3'b100;
  localparam logic [2:0] W_HU = 3'b101;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] mem_address_i;
  logic [2:0]  wr_width_i;
  logic        mem_read_ctrl_i;
  logic        mem_write_ctrl_i;
  logic [31:0] mem_write_data_i;
  logic [31:0] mem_read_data_o;
  logic        mem_ready_o;
  logic        mem_err_o;

  int n_total = 0;
  int n_bad   = 0;
  int n_req   = 0;
  int n_ready = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  dmem_responder #(.BASE_ADDR(B), .DEPTH_WORDS(DEPTH)) dut (
    .clk              (clk),
    .reset            (reset),
    .mem_address_i    (mem_address_i),
    .wr_width_i       (wr_width_i),
    .mem_read_ctrl_i  (mem_read_ctrl_i),
    .mem_write_ctrl_i (mem_write_ctrl_i),
    .mem_write_data_i (mem_write_data_i),
    .mem_read_data_o  (mem_read_data_o),
    .mem_ready_o      (mem_ready_o),
    .mem_err_o        (mem_err_o)
  );

  always @(negedge clk) if (mem_ready_o === 1'b1) n_ready++;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s got=%08h want=%08h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    mem_read_ctrl_i  = 1'b0;
    mem_write_ctrl_i = 1'b0;
    mem_address_i    = 32'd0;
    wr_width_i       = W_W;
    mem_write_data_i = 32'd0;
  endtask

  // Called #1 after a rising edge. Leaves inputs idle #1 after the edge that
  // follows the ready cycle, so a following call is back-to-back.
  task automatic do_req(input string tag, input logic rd, input logic wr,
                        input logic [2:0] w, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp_d,
                        input logic exp_e, input int exp_lat);
    exp_t e;
    exp_t got;
    int   lat;
    mem_read_ctrl_i  = rd;
    mem_write_ctrl_i = wr;
    wr_width_i       = w;
    mem_address_i    = a;
    mem_write_data_i = d;
    e.data = exp_d; e.err = exp_e; e.lat = exp_lat;
    sb_q.push_back(e);
    n_req++;
    lat = 0;
    while (1) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (mem_ready_o === 1'b1) break;
      if (lat >= 8) break;
    end
    got = sb_q.pop_front();
    check_val({tag, " ready"}, 32'(mem_ready_o), 32'd1);
    check_val({tag, " lat"}, 32'(lat), 32'(got.lat));
    check_val({tag, " data"}, mem_read_data_o, got.data);
    check_val({tag, " err"}, 32'(mem_err_o), 32'(got.err));
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst ready", 32'(mem_ready_o), 32'd0);
    check_val("rst err", 32'(mem_err_o), 32'd0);
    check_val("rst data", mem_read_data_o, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    do_req("sw0",  0, 1, W_W,  B + 0, 32'hDEADBEEF, 32'h0, 0, 2);
    do_req("lw0",  1, 0, W_W,  B + 0, 32'h0, 32'hDEADBEEF, 0, 2);
    do_req("lb3",  1, 0, W_B,  B + 3, 32'h0, 32'hFFFFFFDE, 0, 2);
    do_req("lbu3", 1, 0, W_BU, B + 3, 32'h0, 32'h000000DE, 0, 2);
    do_req("lhu2", 1, 0, W_HU, B + 2, 32'h0, 32'h0000DEAD, 0, 2);
    do_req("lh2",  1, 0, W_H,  B + 2, 32'h0, 32'hFFFFDEAD, 0, 2);

    do_req("sh3",  0, 1, W_H,  B + 3, 32'hFFFF1234, 32'h0, 0, 3);
    do_req("lw0b", 1, 0, W_W,  B + 0, 32'h0, 32'h34ADBEEF, 0, 2);
    do_req("lb4",  1, 0, W_B,  B + 4, 32'h0, 32'h00000012, 0, 2);
    do_req("lh3",  1, 0, W_H,  B + 3, 32'h0, 32'h00001234, 0, 3);

    do_req("lwend", 1, 0, W_W, B + 4*DEPTH - 2, 32'h0, 32'h0, 1, 1);
    do_req("rdwr",  1, 1, W_W, B + 0, 32'h11111111, 32'h0, 1, 1);
    do_req("w011",  0, 1, 3'b011, B + 0, 32'h22222222, 32'h0, 1, 1);
    do_req("below", 1, 0, W_W, B - 4, 32'h0, 32'h0, 1, 1);
    do_req("lw0c",  1, 0, W_W, B + 0, 32'h0, 32'h34ADBEEF, 0, 2);

    do_req("swlast", 0, 1, W_W, B + 4*DEPTH - 4, 32'hA5A55A5A, 32'h0, 0, 2);
    do_req("lblast", 1, 0, W_B, B + 4*DEPTH - 1, 32'h0, 32'hFFFFFFA5, 0, 2);
    do_req("lhlast", 1, 0, W_H, B + 4*DEPTH - 1, 32'h0, 32'h0, 1, 1);

    // reset while the store sits in FIRST
    do_req("sw8",  0, 1, W_W, B + 8, 32'h01020304, 32'h0, 0, 2);
    mem_write_ctrl_i = 1'b1;
    wr_width_i       = W_W;
    mem_address_i    = B + 8;
    mem_write_data_i = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_val("rstmid ready", 32'(mem_ready_o), 32'd0);
    check_val("rstmid err", 32'(mem_err_o), 32'd0);
    check_val("rstmid data", mem_read_data_o, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle_inputs();
    @(posedge clk);
    #1;
    do_req("lw8",  1, 0, W_W, B + 8, 32'h0, 32'h01020304, 0, 2);

    // back-to-back: do_req hands over with no idle cycle
    do_req("b2bsw", 0, 1, W_W, B + 12, 32'h55667788, 32'h0, 0, 2);
    do_req("b2blw", 1, 0, W_W, B + 12, 32'h0, 32'h55667788, 0, 2);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("pulses", 32'(n_ready), 32'(n_req));
    check_val("sb empty", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
